// File: rtl/if_stage.sv
// Instruction fetch + IF/ID register: PC drives instAddr, fetched word lands in IF/ID one edge later.
// No valid/ready: stall freezes PC and IF/ID; a redirect flushes IF/ID to a bubble and wins over stall.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [1:0]       PCsrc,
    input  logic [31:0]      branchTarget,
    input  logic [31:0]      instData,
    output logic [31:0]      instAddr,
    output logic [31:0]      ifidInst,
    output logic [31:0]      ifidPC4,
    output logic             ifidValid,
    output logic [CNT_W-1:0] fetchCount,
    output logic [CNT_W-1:0] bubbleCount
);

    localparam logic [31:0]      RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
    localparam logic [CNT_W-1:0] CNT_MAX          = '1;
    localparam logic [CNT_W-1:0] CNT_ONE          = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        MODE_RUN,
        MODE_STALL,
        MODE_BRANCH,
        MODE_JUMP
    } mode_t;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_target;
    mode_t       mode;

    // Redirect outranks stall; PCsrc==3 is reserved and falls through to run/stall.
    always_comb begin
        mode = MODE_RUN;
        if (PCsrc == 2'd1) begin
            mode = MODE_BRANCH;
        end else if (PCsrc == 2'd2) begin
            mode = MODE_JUMP;
        end else if (stall) begin
            mode = MODE_STALL;
        end
    end

    assign pc_plus4 = pc + 32'd4;

    // Jump target is built from the instruction currently held in IF/ID (the one being decoded).
    always_comb begin
        redirect_target = {branchTarget[31:2], 2'b00};
        if (mode == MODE_JUMP) begin
            redirect_target = {ifidPC4[31:28], ifidInst[25:0], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC_ALIGNED;
            ifidInst    <= 32'h0;
            ifidPC4     <= 32'h0;
            ifidValid   <= 1'b0;
            fetchCount  <= '0;
            bubbleCount <= '0;
        end else begin
            unique case (mode)
                MODE_RUN: begin
                    pc        <= pc_plus4;
                    ifidInst  <= instData;
                    ifidPC4   <= pc_plus4;
                    ifidValid <= 1'b1;
                    if (fetchCount != CNT_MAX) begin
                        fetchCount <= fetchCount + CNT_ONE;
                    end
                end
                MODE_BRANCH, MODE_JUMP: begin
                    pc        <= redirect_target;
                    ifidInst  <= 32'h0;
                    ifidPC4   <= 32'h0;
                    ifidValid <= 1'b0;
                    if (bubbleCount != CNT_MAX) begin
                        bubbleCount <= bubbleCount + CNT_ONE;
                    end
                end
                MODE_STALL: begin
                    pc <= pc;
                end
            endcase
        end
    end

    assign instAddr = pc;

endmodule
